// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase controller and its neighbours.
// Provides the phase encoding, the one-hot light codes, the default durations,
// and the phase-to-light decode that the down-counter and display blocks reuse.
package traffic_pkg;

  // Phase FSM encoding, 3 bits. WALK exists only when the pedestrian feature is built.
  typedef enum logic [2:0] {
    PH_NS_G = 3'd0,
    PH_NS_Y = 3'd1,
    PH_RED1 = 3'd2,
    PH_EW_G = 3'd3,
    PH_EW_Y = 3'd4,
    PH_RED2 = 3'd5,
    PH_WALK = 3'd6
  } phase_e;

  // One-hot lamp codes, bit order {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Default phase durations in down-counter ticks.
  localparam int unsigned DEF_GREEN_NS_T = 20;
  localparam int unsigned DEF_GREEN_EW_T = 15;
  localparam int unsigned DEF_YELLOW_T   = 3;
  localparam int unsigned DEF_RED_T      = 2;
  localparam int unsigned DEF_WALK_T     = 10;

  // Returns {ns_light, ew_light} for a phase. Any phase that is not a green or
  // yellow phase (including unused encodings) shows red both ways, so the
  // decode can never light two conflicting directions.
  function automatic logic [5:0] phase_lights(input logic [2:0] ph);
    logic [5:0] l;
    l = {RED, RED};
    case (ph)
      PH_NS_G: l = {GRN, RED};
      PH_NS_Y: l = {YEL, RED};
      PH_EW_G: l = {RED, GRN};
      PH_EW_Y: l = {RED, YEL};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl.sv
// Purpose: phase FSM for the intersection; sequences NS/EW lights and loads the down-counter.
// Latency: outputs decode the state register; a phase of duration D lasts D+2 clk edges.
// Backpressure: none; a stalled counter (never reaching zero) simply holds the current phase.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   counter_value   6-bit value returned by the down-counter
//   ped_req         pedestrian request, level or pulse (TRAFFIC_PED_EN builds only)
//   timer_value     6-bit load value to the down-counter (0 for one cycle on each entry)
//   ns_light        one-hot {red, yellow, green} for north-south
//   ew_light        one-hot {red, yellow, green} for east-west
//   phase           current FSM state encoding
//   walk            walk lamp (TRAFFIC_PED_EN builds only)
//
// Build option: define TRAFFIC_PED_EN to add the pedestrian WALK phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_NS_T = DEF_GREEN_NS_T,
  parameter int unsigned GREEN_EW_T = DEF_GREEN_EW_T,
  parameter int unsigned YELLOW_T   = DEF_YELLOW_T,
  parameter int unsigned RED_T      = DEF_RED_T,
  parameter int unsigned WALK_T     = DEF_WALK_T
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] counter_value,
`ifdef TRAFFIC_PED_EN
  input  logic       ped_req,
`endif
  output logic [5:0] timer_value,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase
`ifdef TRAFFIC_PED_EN
  ,
  output logic       walk
`endif
);

  // Durations must fit the 6-bit counter and be nonzero; a zero duration would
  // be indistinguishable from the gap value and the counter would never reload.
  if (GREEN_NS_T < 1 || GREEN_NS_T > 63) begin : g_bad_green_ns
    $error("GREEN_NS_T must be in 1..63");
  end
  if (GREEN_EW_T < 1 || GREEN_EW_T > 63) begin : g_bad_green_ew
    $error("GREEN_EW_T must be in 1..63");
  end
  if (YELLOW_T < 1 || YELLOW_T > 63) begin : g_bad_yellow
    $error("YELLOW_T must be in 1..63");
  end
  if (RED_T < 1 || RED_T > 63) begin : g_bad_red
    $error("RED_T must be in 1..63");
  end
  if (WALK_T < 1 || WALK_T > 63) begin : g_bad_walk
    $error("WALK_T must be in 1..63");
  end

  // Legacy-style state constants, aliased from the shared package encoding.
  localparam logic [2:0] S_NS_G = PH_NS_G;
  localparam logic [2:0] S_NS_Y = PH_NS_Y;
  localparam logic [2:0] S_RED1 = PH_RED1;
  localparam logic [2:0] S_EW_G = PH_EW_G;
  localparam logic [2:0] S_EW_Y = PH_EW_Y;
  localparam logic [2:0] S_RED2 = PH_RED2;
  localparam logic [2:0] S_WALK = PH_WALK;

  localparam logic [5:0] D_GREEN_NS = GREEN_NS_T[5:0];
  localparam logic [5:0] D_GREEN_EW = GREEN_EW_T[5:0];
  localparam logic [5:0] D_YELLOW   = YELLOW_T[5:0];
  localparam logic [5:0] D_RED      = RED_T[5:0];
  localparam logic [5:0] D_WALK     = WALK_T[5:0];

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       gap;        // high for the single cycle following every state entry
  logic       armed;      // counter has been seen nonzero in this phase
  logic       advance;
  logic       cnt_zero;
  logic [5:0] phase_dur;
  logic       pend;       // pedestrian request waiting for the next all-red exit
  logic       next_ns;    // which green the WALK phase displaced (1 = NS)

  assign cnt_zero = (counter_value == 6'd0);

  // A zero is only trusted once the counter has been seen loaded with this
  // phase's duration; this filters the stale zero left over from the gap.
  assign advance = !gap && armed && cnt_zero;

  always_comb begin
    state_nxt = state;
    case (state)
      S_NS_G:  state_nxt = S_NS_Y;
      S_NS_Y:  state_nxt = S_RED1;
      S_RED1:  state_nxt = pend ? S_WALK : S_EW_G;
      S_EW_G:  state_nxt = S_EW_Y;
      S_EW_Y:  state_nxt = S_RED2;
      S_RED2:  state_nxt = pend ? S_WALK : S_NS_G;
      S_WALK:  state_nxt = next_ns ? S_NS_G : S_EW_G;
      default: state_nxt = S_RED2;
    endcase
  end

  always_comb begin
    phase_dur = D_RED;
    case (state)
      S_NS_G:  phase_dur = D_GREEN_NS;
      S_NS_Y:  phase_dur = D_YELLOW;
      S_RED1:  phase_dur = D_RED;
      S_EW_G:  phase_dur = D_GREEN_EW;
      S_EW_Y:  phase_dur = D_YELLOW;
      S_RED2:  phase_dur = D_RED;
      S_WALK:  phase_dur = D_WALK;
      default: phase_dur = D_RED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RED2;
      gap   <= 1'b1;
      armed <= 1'b0;
    end else if (advance) begin
      state <= state_nxt;
      gap   <= 1'b1;
      armed <= 1'b0;
    end else begin
      gap <= 1'b0;
      if (!gap && !cnt_zero) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef TRAFFIC_PED_EN
  // Requests are latched until the next all-red exit; anything arriving while
  // WALK is already showing is dropped since the pedestrian is being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      next_ns <= 1'b0;
    end else if (advance && (state_nxt == S_WALK)) begin
      pend    <= 1'b0;
      next_ns <= (state == S_RED2);
    end else if (ped_req && (state != S_WALK)) begin
      pend <= 1'b1;
    end
  end

  assign walk = (state == S_WALK);
`else
  assign pend    = 1'b0;
  assign next_ns = 1'b1;
`endif

  // Zero during the gap forces a visible value change to the counter, so it
  // reloads even when consecutive phases share a duration.
  assign timer_value = gap ? 6'd0 : phase_dur;
  assign phase       = state;
  assign {ns_light, ew_light} = phase_lights(state);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic [5:0] counter_value;
  logic [5:0] timer_value;
  logic [2:0] ns_light, ew_light, phase;
  logic [5:0] counter2;
  logic [5:0] timer2;
  logic [2:0] ns2, ew2, phase2;
`ifdef TRAFFIC_PED_EN
  logic       ped_req = 1'b0;
  logic       walk;
  logic       ped_req2 = 1'b0;
  logic       walk2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Down-counter models: sample timer_value on the falling edge, reload on any
  // change of the sampled value, otherwise count down and stick at zero.
  logic [5:0] cnt_a = '0, prev_a = '0;
  logic [5:0] cnt_b = '0, prev_b = '0;
  logic       cm_hold = 1'b0;
  logic [5:0] cm_val = '0;

  always @(negedge clk) begin
    if (timer_value != prev_a) cnt_a <= timer_value;
    else if (cnt_a != 6'd0)    cnt_a <= cnt_a - 6'd1;
    prev_a <= timer_value;
  end

  always @(negedge clk) begin
    if (timer2 != prev_b)      cnt_b <= timer2;
    else if (cnt_b != 6'd0)    cnt_b <= cnt_b - 6'd1;
    prev_b <= timer2;
  end

  assign counter_value = cm_hold ? cm_val : cnt_a;
  assign counter2      = cnt_b;

  traffic_phase_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .counter_value (counter_value),
`ifdef TRAFFIC_PED_EN
    .ped_req       (ped_req),
`endif
    .timer_value   (timer_value),
    .ns_light      (ns_light),
    .ew_light      (ew_light),
    .phase         (phase)
`ifdef TRAFFIC_PED_EN
    ,
    .walk          (walk)
`endif
  );

  traffic_phase_ctrl #(.GREEN_NS_T(3), .YELLOW_T(3)) u_eq (
    .clk           (clk),
    .rst_n         (rst2_n),
    .counter_value (counter2),
`ifdef TRAFFIC_PED_EN
    .ped_req       (ped_req2),
`endif
    .timer_value   (timer2),
    .ns_light      (ns2),
    .ew_light      (ew2),
    .phase         (phase2)
`ifdef TRAFFIC_PED_EN
    ,
    .walk          (walk2)
`endif
  );

  typedef struct {
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    int         dur;
    int         len;
  } ring_vec_t;

  ring_vec_t ring [6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] p, input int bound, input string name);
    int n;
    n = 0;
    while (phase != p && n < bound) begin
      step();
      n++;
    end
    chk(name, phase, p);
  endtask

  // Counts edges until the phase changes; records timer_value after the gap
  // edge and any cycle where both directions show non-red.
  task automatic run_phase(output int len, output int tv1, output int viol);
    logic [2:0] start;
    start = phase;
    len = 0;
    tv1 = 0;
    viol = 0;
    do begin
      step();
      len++;
      if (len == 1) tv1 = timer_value;
      if (ns_light != 3'b100 && ew_light != 3'b100) viol++;
    end while (phase == start && len < 200);
  endtask

  initial begin
    int len, tv1, viol, n;

    ring[0] = '{3'd0, 3'b001, 3'b100, 20, 22};
    ring[1] = '{3'd1, 3'b010, 3'b100,  3,  5};
    ring[2] = '{3'd2, 3'b100, 3'b100,  2,  4};
    ring[3] = '{3'd3, 3'b100, 3'b001, 15, 17};
    ring[4] = '{3'd4, 3'b100, 3'b010,  3,  5};
    ring[5] = '{3'd5, 3'b100, 3'b100,  2,  4};

    // Reset state and first edges after release
    step();
    chk("rst_phase", phase, 5);
    chk("rst_timer", timer_value, 0);
    chk("rst_ns", ns_light, 3'b100);
    chk("rst_ew", ew_light, 3'b100);
`ifdef TRAFFIC_PED_EN
    chk("rst_walk", walk, 0);
`endif
    rst_n = 1'b1;
    step();
    chk("rel_edge1_timer", timer_value, 2);
    chk("rel_edge1_phase", phase, 5);
    n = 1;
    while (phase != 3'd0 && n < 50) begin
      step();
      n++;
    end
    chk("first_ns_g_edge", n, 4);

    // Full ring from NS_G entry, table-driven
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ring%0d_phase", i), phase, ring[i].ph);
      chk($sformatf("ring%0d_ns", i), ns_light, ring[i].ns);
      chk($sformatf("ring%0d_ew", i), ew_light, ring[i].ew);
      chk($sformatf("ring%0d_gap", i), timer_value, 0);
      run_phase(len, tv1, viol);
      chk($sformatf("ring%0d_dur", i), tv1, ring[i].dur);
      chk($sformatf("ring%0d_len", i), len, ring[i].len);
      chk($sformatf("ring%0d_conflict", i), viol, 0);
    end
    chk("ring_wrap_phase", phase, 0);

    // Equal adjacent durations (GREEN_NS_T = YELLOW_T = 3)
    rst2_n = 1'b1;
    n = 0;
    while (phase2 != 3'd0 && n < 50) begin
      step();
      n++;
    end
    chk("eq_ns_g_entry", phase2, 0);
    n = 0;
    while (phase2 == 3'd0 && n < 50) begin
      step();
      n++;
    end
    chk("eq_ns_g_len", n, 5);
    chk("eq_ns_y_phase", phase2, 1);
    chk("eq_ns_y_gap", timer2, 0);
    chk("eq_ns_y_ns", ns2, 3'b010);
    chk("eq_ns_y_ew", ew2, 3'b100);
    step();
    n = 1;
    chk("eq_ns_y_timer", timer2, 3);
    @(negedge clk);
    #1;
    chk("eq_ns_y_reload", counter2, 3);
    while (phase2 == 3'd1 && n < 50) begin
      step();
      n++;
    end
    chk("eq_ns_y_len", n, 5);
    chk("eq_after_ns_y", phase2, 2);

`ifdef TRAFFIC_PED_EN
    // Pedestrian request during EW_G produces one WALK after RED2
    wait_phase(3'd3, 100, "ped_wait_ew_g");
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase(3'd5, 100, "ped_wait_red2");
    run_phase(len, tv1, viol);
    chk("ped_walk_phase", phase, 6);
    chk("ped_walk_lamp", walk, 1);
    chk("ped_walk_ns", ns_light, 3'b100);
    chk("ped_walk_ew", ew_light, 3'b100);
    n = 0;
    while (phase == 3'd6 && n < 50) begin
      step();
      n++;
      if (n == 3) ped_req = 1'b1;
      if (n == 4) ped_req = 1'b0;
    end
    chk("ped_walk_len", n, 12);
    chk("ped_after_walk", phase, 0);
    chk("ped_walk_off", walk, 0);
    wait_phase(3'd2, 100, "ped_wait_red1");
    run_phase(len, tv1, viol);
    chk("ped_no_rewalk_red1", phase, 3);
    wait_phase(3'd5, 100, "ped_wait_red2b");
    run_phase(len, tv1, viol);
    chk("ped_no_rewalk_red2", phase, 0);
`endif

    // Reset mid-EW_G with a nonzero counter
    wait_phase(3'd3, 100, "rstmid_wait_ew_g");
    step();
    step();
    cm_val  = 6'd9;
    cm_hold = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rstmid_phase", phase, 5);
    chk("rstmid_timer", timer_value, 0);
    chk("rstmid_ns", ns_light, 3'b100);
    chk("rstmid_ew", ew_light, 3'b100);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rstmid_edge1_phase", phase, 5);
    chk("rstmid_edge1_timer", timer_value, 2);
    cm_hold = 1'b0;
    n = 1;
    while (phase != 3'd0 && n < 50) begin
      step();
      n++;
    end
    chk("rstmid_ns_g_edge", n, 4);

    // Counter stuck at zero from NS_G entry: never arms, never advances
    cm_val  = 6'd0;
    cm_hold = 1'b1;
    for (int i = 0; i < 60; i++) step();
    chk("stall_phase", phase, 0);
    chk("stall_ns", ns_light, 3'b001);
    chk("stall_timer", timer_value, 20);
    cm_hold = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stall_not_armed", phase, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

- Upstream phase controller for the intersection.
- Sequences the north-south / east-west light phases and drives the 6-bit `timer_value` consumed by the down-counter.
- Advances on the down-counter's returned `counter_value` reaching zero.
- Owns the phase FSM, the light encodings and the optional pedestrian walk phase.

## Interface
- `GREEN_NS_T`, 20: NS green duration in counter ticks, legal 1..63.
- `GREEN_EW_T`, 15: EW green duration, legal 1..63.
- `YELLOW_T`, 3: yellow duration (both directions), legal 1..63.
- `RED_T`, 2: all-red clearance duration, legal 1..63.
- `WALK_T`, 10: pedestrian walk duration, legal 1..63; used only with `TRAFFIC_PED_EN`.
- `clk` in 1: single clock; this block acts on the rising edge. The down-counter samples `timer_value` on the falling edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `counter_value` in 6: current value returned by the down-counter.
- `ped_req` in 1: pedestrian request, synchronous to `clk`, level or pulse (present only with `TRAFFIC_PED_EN`).
- `timer_value` out 6: duration load value presented to the down-counter.
- `ns_light` out 3: one-hot {red, yellow, green}.
- `ew_light` out 3: one-hot {red, yellow, green}.
- `phase` out 3: current FSM state encoding.
- `walk` out 1: walk lamp (present only with `TRAFFIC_PED_EN`).

## Operation
- States and encodings:
  - NS_G=0, NS_Y=1, RED1=2, EW_G=3, EW_Y=4, RED2=5, WALK=6.
  - Base ring: NS_G→NS_Y→RED1→EW_G→EW_Y→RED2→NS_G.
- Lights:
  - NS_G: ns=green, ew=red.
  - NS_Y: ns=yellow, ew=red.
  - EW_G: ns=red, ew=green.
  - EW_Y: ns=red, ew=yellow.
  - RED1, RED2, WALK: both red.
  - Never green or yellow on both directions at once.
- Gap cycle:
  - On every state entry, `timer_value`=0 for exactly one cycle (gap=1).
  - Then `timer_value`=the phase duration for the rest of the phase.
  - This guarantees the counter sees a value change, so it reloads even when adjacent phases have equal durations.
- Arm/advance:
  - `armed` clears on state entry.
  - `armed` sets on a rising edge where gap=0 and `counter_value`≠0.
  - The state advances on the rising edge where armed=1 and `counter_value`=0.
  - `counter_value` is ignored while gap=1 or armed=0, so a stale zero can never cause a double advance.
- Widths: all durations are 6-bit unsigned. A duration of 0 or >63 is an elaboration-time error.

## Timing
- Phase of duration D occupies exactly D+2 rising edges from entry to the next entry.
- Reset values, applied immediately on `rst_n` low:
  - state=RED2, gap=1, armed=0
  - `timer_value`=0, `phase`=5
  - `ns_light`=`ew_light`=3'b100
  - `walk`=0, ped pending=0
- After reset release:
  - First edge: `timer_value`=RED_T.
  - First green (NS_G) entered RED_T+2 edges after release.
- Reset mid-phase: abandon the phase; restart at RED2 with a gap. The counter may hold a nonzero value; it is ignored until armed.
- `counter_value` nonzero forever (counter stalled): the controller holds its state indefinitely. No watchdog.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - `ped_req` sampled high sets `ped_pending`.
  - On exit from RED1 or RED2 with pending=1, go to WALK instead of the next green. WALK duration is WALK_T, with `walk`=1 and both directions red.
  - A `next_ns` bit records the skipped green. WALK exits to NS_G if it was entered from RED2, else to EW_G.
  - Pending clears on WALK entry. `ped_req` high during WALK is ignored.
- Undefined: no `ped_req`/`walk` ports, state 6 unreachable, pure base ring.

## Structure
- Shared package `traffic_pkg`:
  - Phase state enum (3-bit).
  - Light one-hot constants RED=3'b100, YEL=3'b010, GRN=3'b001.
  - Default duration constants.
  - Function mapping phase→{ns_light, ew_light}; the down-counter and display blocks reuse these.
- Single module, no sub-module. Light decode is the package function; the FSM, gap/arm logic and pending latch are small enough to stay inline.

## Test plan
- Reset release, counter model attached, defaults:
  - `timer_value` 0 then 2.
  - NS_G entered at edge 4.
  - `ns_light`=001 lasting 22 edges, then NS_Y lasting 5 edges.
- Full ring, defaults: phase sequence 5,0,1,2,3,4,5,0. Per-phase lengths are 22,5,4,17,5,4 edges, and no cycle has both lights non-red.
- Set GREEN_NS_T=YELLOW_T=3: the counter reloads 3 at NS_Y entry (via gap 0); NS_Y lasts 5 edges and does not skip.
- `TRAFFIC_PED_EN`, pulse `ped_req` during EW_G:
  - After RED2, phase=6 with `walk`=1 for 12 edges.
  - Then NS_G follows.
  - A second pulse during WALK causes no further WALK.
- Assert `rst_n` low mid-EW_G with `counter_value`=9: outputs take reset values immediately. After release, RED2 is held until the counter is reloaded to 2 and reaches 0, then NS_G follows.
- Force `counter_value`=0 permanently after NS_G entry: armed never sets and the state stays NS_G.
